pipeline_accum_stage: RTL and testbench

- Downstream neighbour of the 3-stage pipeline unit. It consumes that unit's 32-bit data, valid and flush outputs, and drives the stall input back into it.
- Buffers accepted words in a small FIFO and sums them in fixed-size groups.
- Presents one group sum per group to the next stage, using the same valid/stall/flush protocol.

---
 rtl/pipeline_accum_stage.sv | 160 ++++++++++++++++
 tb/tb_pipeline_accum_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_accum_stage.sv
// -----------------------------------------------------------------------------
// pipeline_accum_stage
//
// Purpose:
//     Downstream neighbour of the 3-stage pipeline unit. Accepted 32-bit words
//     are buffered in a small circular FIFO, then summed in groups of GROUP
//     words. Each completed group sum is presented to the next stage with the
//     same valid/stall/flush handshake that the upstream unit uses.
//
// Optional feature (compile-time macro):
//     ACC_SATURATE_EN - when defined, every accumulator addition clamps at
//                       2^ACC_W-1. When undefined, additions wrap modulo
//                       2^ACC_W and no clamp logic exists.
//
// Parameters:
//     DEPTH  - input FIFO entries (>= 2)
//     GROUP  - words summed per result (>= 1)
//     ACC_W  - accumulator / result width (>= 32, inputs zero-extended)
//
// Ports:
//     clk        in   1      single clock, rising edge
//     reset      in   1      synchronous active-low reset
//     in_flush   in   1      flush from upstream stage
//     inputs     in   32     data word from upstream
//     in_valid   in   1      upstream word valid
//     in_stall   in   1      downstream stall, hold current result
//     outputs    out  ACC_W  group sum
//     out_valid  out  1      outputs holds a valid sum
//     out_flush  out  1      flush forwarded downstream (in_flush delayed 1)
//     out_stall  out  1      stall to upstream, high when FIFO full
// -----------------------------------------------------------------------------
module pipeline_accum_stage #(
    parameter int DEPTH = 2,
    parameter int GROUP = 4,
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_flush,
    input  logic [31:0]      inputs,
    input  logic             in_valid,
    input  logic             in_stall,
    output logic [ACC_W-1:0] outputs,
    output logic             out_valid,
    output logic             out_flush,
    output logic             out_stall
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int GRP_W = (GROUP > 1) ? $clog2(GROUP) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUP - 1);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [GRP_W-1:0] r_grp_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_outputs;
    logic             r_out_valid;
    logic             r_out_flush;

    logic             w_full;
    logic             w_hold;
    logic             w_push;
    logic             w_pop;
    logic             w_last;
    logic [31:0]      w_rd_word;
    logic [ACC_W-1:0] w_sum;

    // out_stall comes only from the registered count, so upstream never sees
    // a combinational path from in_valid or in_stall.
    always_comb begin
        w_full    = (r_count == CNT_FULL);
        w_hold    = r_out_valid & in_stall;
        w_push    = in_valid & ~w_full & ~in_flush;
        w_pop     = (r_count != '0) & ~w_hold;
        w_last    = (r_grp_cnt == GRP_LAST);
        w_rd_word = r_mem[r_rd_ptr];
    end

`ifdef ACC_SATURATE_EN
    // One extra bit catches the carry; any carry pins the sum at all-ones.
    logic [ACC_W:0] w_sum_full;
    assign w_sum_full = {1'b0, r_acc} + {1'b0, ACC_W'(w_rd_word)};
    assign w_sum      = w_sum_full[ACC_W] ? '1 : w_sum_full[ACC_W-1:0];
`else
    assign w_sum = r_acc + ACC_W'(w_rd_word);
`endif

    // Storage needs no reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= inputs;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_grp_cnt   <= '0;
            r_acc       <= '0;
            r_outputs   <= '0;
            r_out_valid <= 1'b0;
            r_out_flush <= 1'b0;
        end else begin
            r_out_flush <= in_flush;
            if (in_flush) begin
                // Flush beats any push or completing pop in the same cycle.
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_grp_cnt   <= '0;
                r_acc       <= '0;
                r_outputs   <= '0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase

                if (w_pop) begin
                    if (w_last) begin
                        r_outputs   <= w_sum;
                        r_out_valid <= 1'b1;
                        r_acc       <= '0;
                        r_grp_cnt   <= '0;
                    end else begin
                        r_acc       <= w_sum;
                        r_grp_cnt   <= r_grp_cnt + GRP_W'(1);
                        r_out_valid <= 1'b0;
                    end
                end else if (!w_hold) begin
                    // outputs keeps its last value once valid drops.
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign outputs   = r_outputs;
    assign out_valid = r_out_valid;
    assign out_flush = r_out_flush;
    assign out_stall = w_full;

endmodule

// File: tb/tb_pipeline_accum_stage.sv
// -----------------------------------------------------------------------------
// tb_pipeline_accum_stage
//
// Self-checking bench for pipeline_accum_stage. A queue-based behavioural
// model tracks the expected outputs of the GROUP=4 instance every cycle; a
// second GROUP=1 instance is exercised with directed literal expectations.
// Honours ACC_SATURATE_EN for the all-ones group result.
// -----------------------------------------------------------------------------
module tb_pipeline_accum_stage;

    localparam int DEPTH = 2;
    localparam int GROUP = 4;
    localparam int ACC_W = 32;

`ifdef ACC_SATURATE_EN
    localparam logic [31:0] EXP_FF = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] EXP_FF = 32'hFFFF_FFFC;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              flush;
    logic              valid;
    logic              stall;
    logic [31:0]       din;
    logic [ACC_W-1:0]  dout;
    logic              out_valid;
    logic              out_flush;
    logic              out_stall;

    logic              g_flush;
    logic              g_valid;
    logic              g_stall;
    logic [31:0]       g_din;
    logic [31:0]       g_dout;
    logic              g_out_valid;
    logic              g_out_flush;
    logic              g_out_stall;

    pipeline_accum_stage #(.DEPTH(DEPTH), .GROUP(GROUP), .ACC_W(ACC_W)) u_dut (
        .clk       (clk),
        .reset     (rst_n),
        .in_flush  (flush),
        .inputs    (din),
        .in_valid  (valid),
        .in_stall  (stall),
        .outputs   (dout),
        .out_valid (out_valid),
        .out_flush (out_flush),
        .out_stall (out_stall)
    );

    pipeline_accum_stage #(.DEPTH(2), .GROUP(1), .ACC_W(32)) u_g1 (
        .clk       (clk),
        .reset     (rst_n),
        .in_flush  (g_flush),
        .inputs    (g_din),
        .in_valid  (g_valid),
        .in_stall  (g_stall),
        .outputs   (g_dout),
        .out_valid (g_out_valid),
        .out_flush (g_out_flush),
        .out_stall (g_out_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: words waiting in a queue, running group sum.
    // ------------------------------------------------------------------
    logic [31:0] m_q[$];
    logic [31:0] m_acc = '0;
    logic [31:0] m_out = '0;
    int          m_grp = 0;
    bit          m_ov  = 1'b0;
    bit          m_of  = 1'b0;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ACC_SATURATE_EN
        if (s[32]) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    task automatic model_step();
        logic [31:0] w;
        bit full, hold, push, pop;
        if (!rst_n) begin
            m_q.delete();
            m_acc = '0; m_grp = 0; m_out = '0; m_ov = 1'b0; m_of = 1'b0;
            return;
        end
        full = (m_q.size() == DEPTH);
        hold = m_ov && stall;
        push = valid && !full && !flush;
        pop  = (m_q.size() != 0) && !hold;
        m_of = flush;
        if (flush) begin
            m_q.delete();
            m_acc = '0; m_grp = 0; m_out = '0; m_ov = 1'b0;
            return;
        end
        if (pop) begin
            w = m_q.pop_front();
            if (m_grp == GROUP - 1) begin
                m_out = m_add(m_acc, w);
                m_ov  = 1'b1;
                m_acc = '0;
                m_grp = 0;
            end else begin
                m_acc = m_add(m_acc, w);
                m_grp++;
                m_ov  = 1'b0;
            end
        end else if (!hold) begin
            m_ov = 1'b0;
        end
        if (push) m_q.push_back(din);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare process: every cycle once the first reset edge has happened.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("m_outputs",   dout,      m_out);
                chk("m_out_valid", out_valid, m_ov);
                chk("m_out_flush", out_flush, m_of);
                chk("m_out_stall", out_stall, (m_q.size() == DEPTH));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic send(input logic [31:0] w);
        int  tries;
        bit  taken;
        valid = 1'b1;
        din   = w;
        tries = 0;
        forever begin
            taken = !out_stall && !flush;
            @(negedge clk);
            if (taken) break;
            tries++;
            if (tries > 50) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        valid = 1'b0;
    endtask

    task automatic g_send(input logic [31:0] w);
        int  tries;
        bit  taken;
        g_valid = 1'b1;
        g_din   = w;
        tries   = 0;
        forever begin
            taken = !g_out_stall;
            @(negedge clk);
            if (taken) break;
            tries++;
            if (tries > 50) begin
                chk("g_send_timeout", 1, 0);
                break;
            end
        end
        g_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [31:0] exp, input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                chk(name, dout, exp);
                return;
            end
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    logic [31:0] g_got[$];
    logic [31:0] g_prev_out;
    bit          g_prev_hold;

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b1; stall = 1'b0; din = 32'd7;
        g_flush = 1'b0; g_valid = 1'b0; g_stall = 1'b0; g_din = '0;

        // Reset held for two edges while a word is offered.
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs",   dout,      0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_stall", out_stall, 0);
        chk("rst_out_flush", out_flush, 0);
        rst_n = 1'b1; valid = 1'b0; din = '0;
        repeat (3) @(negedge clk);
        chk("rst_no_word", out_stall, 0);

        // 1,2,3,4 back to back: result in second cycle after word 4's edge.
        send(1); send(2); send(3); send(4);
        chk("lat_early", out_valid, 0);
        @(negedge clk);
        chk("lat_valid", out_valid, 1);
        chk("lat_sum",   dout,      10);
        @(negedge clk);
        chk("lat_pulse", out_valid, 0);

        // Stall from the first result while feeding words.
        stall = 1'b1;
        for (int k = 1; k <= 6; k++) send(k);
        repeat (2) @(negedge clk);
        chk("stall_hold_sum",   dout,      10);
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_full",       out_stall, 1);
        stall = 1'b0;
        fork
            begin
                for (int k = 7; k <= 12; k++) send(k);
            end
            begin
                wait_result(26, "stall_r26");
                wait_result(42, "stall_r42");
            end
        join

        // Flush mid-group.
        repeat (4) @(negedge clk);
        send(5); send(6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_out_flush", out_flush, 1);
        chk("flush_out_valid", out_valid, 0);
        @(negedge clk);
        chk("flush_one_cycle", out_flush, 0);
        send(1); send(1); send(1); send(1);
        wait_result(4, "flush_no_residue");

        // All-ones group.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) send(32'hFFFF_FFFF);
        wait_result(EXP_FF, "ones_sum");

        // GROUP=1 instance: stall toggling, results held and in order.
        g_prev_hold = 1'b0;
        g_prev_out  = '0;
        fork
            begin
                g_send(9); g_send(8); g_send(7);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (g_prev_hold) begin
                        chk("g1_hold_valid", g_out_valid, 1);
                        chk("g1_hold_value", g_dout,      g_prev_out);
                    end else if (g_out_valid === 1'b1) begin
                        g_got.push_back(g_dout);
                    end
                    g_stall     = ~g_stall;
                    g_prev_hold = (g_out_valid === 1'b1) && g_stall;
                    g_prev_out  = g_dout;
                end
            end
        join
        g_stall = 1'b0;
        chk("g1_count", g_got.size(), 3);
        if (g_got.size() == 3) begin
            chk("g1_first",  g_got[0], 9);
            chk("g1_second", g_got[1], 8);
            chk("g1_third",  g_got[2], 7);
        end
        chk("g1_no_flush", g_out_flush, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 19) == 0);
            valid = ($urandom_range(0, 3) != 0);
            stall = ($urandom_range(0, 2) == 0);
            din   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | $urandom_range(0, 255))
                                                : $urandom_range(0, 15);
            @(negedge clk);
        end
        rst_n = 1'b1; flush = 1'b0; valid = 1'b0; stall = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
